// File: rtl/dma_capture_sequencer.sv
// ---------------------------------------------------------------------------
// dma_capture_sequencer : fills the capture BRAM with decimated samples, then
// kicks dma_controller and tracks the offload to completion.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dma_capture_sequencer #(
   parameter int DEPTH       = 16384,
   parameter int ADDR_W      = 14,
   parameter int ENABLE_HOLD = 4,
   parameter int TIMEOUT     = 1048576
) (
   input  logic              aclk,
   input  logic              rst_i,
   input  logic              arm_i,
   input  logic              trig_mode_i,
   input  logic              trig_i,
   input  logic [15:0]       decim_i,
   input  logic [63:0]       sample_i,
   output logic              bram_we_o,
   output logic [ADDR_W-1:0] bram_waddr_o,
   output logic [63:0]       bram_wdata_o,
   output logic              dma_enable_o,
   input  logic              dma_ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic [2:0]        state_o,
   output logic [15:0]       capture_count_o
);

   localparam int TMR_W  = $clog2(TIMEOUT + 1);
   localparam int HOLD_W = $clog2(ENABLE_HOLD + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ENABLE_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_TRIG = 3'd1,
      S_CAPTURE   = 3'd2,
      S_KICK      = 3'd3,
      S_WAIT_BUSY = 3'd4,
      S_WAIT_DONE = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t              state, state_nx;
   logic [15:0]         decim;
   logic [15:0]         dcnt;
   logic [ADDR_W-1:0]   waddr;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [TMR_W-1:0]    timer;
   logic                trig_prev;
   logic                accept, store, timed_out;

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      store     = 1'b0;
      timed_out = 1'b0;
      case (state)
         S_IDLE: begin
            if (arm_i && dma_ready_i) begin
               accept   = 1'b1;
               state_nx = trig_mode_i ? S_WAIT_TRIG : S_CAPTURE;
            end
         end
         S_WAIT_TRIG: begin
            if (trig_i && !trig_prev) state_nx = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (dcnt == 16'd0) begin
               store = 1'b1;
               if (waddr == LAST_ADDR) state_nx = S_KICK;
            end
         end
         S_KICK: begin
            if (hold_cnt == HOLD_LAST) state_nx = S_WAIT_BUSY;
         end
         // The awaited ready level is checked before the timer so it wins a tie.
         S_WAIT_BUSY: begin
            if (!dma_ready_i) state_nx = S_WAIT_DONE;
            else if (timer == TMR_LAST) begin
               timed_out = 1'b1;
               state_nx  = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (dma_ready_i) state_nx = S_DONE;
            else if (timer == TMR_LAST) begin
               timed_out = 1'b1;
               state_nx  = S_IDLE;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst_i) begin
         state           <= S_IDLE;
         decim           <= '0;
         dcnt            <= '0;
         waddr           <= '0;
         hold_cnt        <= '0;
         timer           <= '0;
         trig_prev       <= 1'b0;
         bram_we_o       <= 1'b0;
         bram_waddr_o    <= '0;
         bram_wdata_o    <= '0;
         dma_enable_o    <= 1'b0;
         done_o          <= 1'b0;
         timeout_o       <= 1'b0;
         capture_count_o <= '0;
      end else begin
         state        <= state_nx;
         trig_prev    <= trig_i;
         bram_we_o    <= store;
         dma_enable_o <= (state_nx == S_KICK);
         done_o       <= (state_nx == S_DONE);

         if (accept) begin
            decim     <= decim_i;
            dcnt      <= '0;
            waddr     <= '0;
            timeout_o <= 1'b0;
         end

         if (state == S_CAPTURE) begin
            if (store) begin
               bram_waddr_o <= waddr;
               bram_wdata_o <= sample_i;
               waddr        <= waddr + 1'b1;
               dcnt         <= decim;
            end else begin
               dcnt <= dcnt - 1'b1;
            end
         end

         hold_cnt <= (state == S_KICK) ? hold_cnt + 1'b1 : '0;

         // Timer restarts whenever a wait state is (re)entered.
         if ((state_nx == state) && ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)))
            timer <= timer + 1'b1;
         else
            timer <= '0;

         if (timed_out) timeout_o <= 1'b1;
         if (state_nx == S_DONE) capture_count_o <= capture_count_o + 1'b1;
      end
   end

   assign busy_o  = (state != S_IDLE);
   assign state_o = state;

endmodule

`default_nettype wire
